vex_bus_arbiter: RTL

Parametrised N-master to 1-slave arbiter for VexRiscv simple-bus traffic: it merges the core's iBus, dBus and any extra requesters, such as a DMA or debug master, onto one memory port. Commands are granted round-robin with a grant lock that holds until the command is accepted. Read responses return in order and are routed back to the originating master through an outstanding-request FIFO. It sits between the CPU wrapper's bus interfaces and the shared memory model/interconnect.

---
 rtl/vex_bus_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/vex_bus_arbiter.sv
// N-master to 1-slave simple-bus arbiter with in-order read response routing.
// Define VEX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module vex_bus_arbiter #(
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_PORTS-1:0]                  m_cmd_valid,
   output logic [NUM_PORTS-1:0]                  m_cmd_ready,
   input  logic [NUM_PORTS-1:0]                  m_cmd_wr,
   input  logic [NUM_PORTS*ADDR_W-1:0]           m_cmd_address,
   input  logic [NUM_PORTS*DATA_W-1:0]           m_cmd_data,
   input  logic [NUM_PORTS*DATA_W/8-1:0]         m_cmd_mask,
   input  logic [NUM_PORTS*2-1:0]                m_cmd_size,
   output logic [NUM_PORTS-1:0]                  m_rsp_valid,
   output logic [DATA_W-1:0]                     m_rsp_data,
   output logic                                  m_rsp_error,
   output logic                                  s_cmd_valid,
   input  logic                                  s_cmd_ready,
   output logic                                  s_cmd_wr,
   output logic [ADDR_W-1:0]                     s_cmd_address,
   output logic [DATA_W-1:0]                     s_cmd_data,
   output logic [DATA_W/8-1:0]                   s_cmd_mask,
   output logic [1:0]                            s_cmd_size,
   input  logic                                  s_rsp_valid,
   input  logic [DATA_W-1:0]                     s_rsp_data,
   input  logic                                  s_rsp_error,
   output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
   output logic                                  orphan_rsp
);

   localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned MASK_W = DATA_W / 8;

   typedef enum logic {
      ST_OPEN,
      ST_LOCKED
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
   logic [IDX_W-1:0]     winner;
   logic [IDX_W-1:0]     grant;
   logic                 found;
   logic                 any_valid;
   logic                 accept;
   logic                 push;
   logic                 pop;
   logic                 fifo_empty;

   logic [IDX_W-1:0]     fifo_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 full_q, full_d;
   logic                 orphan_q, orphan_d;
   logic [IDX_W-1:0]     rsp_head;

`ifdef VEX_ARB_FIXED_PRIO_EN
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (!found && m_cmd_valid[i]) begin
            winner = IDX_W'(i);
            found  = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0]     rr_q, rr_d;
   int unsigned          rr_idx;

   // Scan from rr upward, wrapping, and take the first requester.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      rr_idx = 0;
      for (int unsigned off = 0; off < NUM_PORTS; off++) begin
         rr_idx = off + 32'(rr_q);
         if (rr_idx >= NUM_PORTS) begin
            rr_idx = rr_idx - NUM_PORTS;
         end
         if (!found && m_cmd_valid[rr_idx]) begin
            winner = IDX_W'(rr_idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (accept) begin
         rr_d = (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   assign any_valid   = |m_cmd_valid;
   assign s_cmd_valid = any_valid & ~full_q;
   assign accept      = s_cmd_valid & s_cmd_ready;

   // A stalled grant is frozen so the slave payload cannot change mid-handshake.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      grant      = winner;
      case (state_q)
         ST_OPEN: begin
            if (s_cmd_valid && !s_cmd_ready) begin
               state_d    = ST_LOCKED;
               lock_idx_d = winner;
            end
         end
         ST_LOCKED: begin
            grant = lock_idx_q;
            if (!s_cmd_valid || s_cmd_ready) begin
               state_d = ST_OPEN;
            end
         end
         default: begin
            state_d = ST_OPEN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_OPEN;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   assign s_cmd_wr      = m_cmd_wr[grant];
   assign s_cmd_address = m_cmd_address[grant*ADDR_W +: ADDR_W];
   assign s_cmd_data    = m_cmd_data[grant*DATA_W +: DATA_W];
   assign s_cmd_mask    = m_cmd_mask[grant*MASK_W +: MASK_W];
   assign s_cmd_size    = m_cmd_size[grant*2 +: 2];

   always_comb begin
      m_cmd_ready = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         m_cmd_ready[i] = accept && (grant == IDX_W'(i));
      end
   end

   assign fifo_empty = (count_q == '0);
   assign push       = accept & ~s_cmd_wr;
   assign pop        = s_rsp_valid & ~fifo_empty;
   assign rsp_head   = fifo_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      orphan_d = orphan_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (s_rsp_valid && fifo_empty) begin
         orphan_d = 1'b1;
      end
   end

   // Full is registered: a pop while full only reopens commands next cycle.
   assign full_d = (count_d == CNT_W'(MAX_OUTSTANDING));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         orphan_q <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         orphan_q <= orphan_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= grant;
         end
      end
   end

   always_comb begin
      m_rsp_valid = '0;
      if (pop) begin
         m_rsp_valid[rsp_head] = 1'b1;
      end
   end

   assign m_rsp_data  = s_rsp_data;
   assign m_rsp_error = s_rsp_error;
   assign outstanding = count_q;
   assign orphan_rsp  = orphan_q;

endmodule
